vend_controller: RTL and testbench

- Top-level sequencer for the vending machine datapath.
- Accumulates coin credit, evaluates product selection against per-product prices, and drives the dispenser through a req/done handshake.
- Returns change one Rs5 coin at a time through a req/ack handshake with the coin ejector.
- Handles cancel and inactivity timeout with a full refund. Sits between the coin acceptor/keypad and the dispenser/ejector actuators.

---
 rtl/vend_pkg.sv | 41 ++++
 rtl/vend_timeout_ctr.sv | 48 ++++
 rtl/vend_controller.sv | 203 ++++++++++++++++++++
 tb/tb_vend_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types, encodings and helpers for the vending controller.
//               Holds the FSM state enum, coin and selection encodings, the
//               change unit, and coin_value() which maps a coin code to rupees.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } vend_state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [1:0] SEL_A = 2'b01;
  localparam logic [1:0] SEL_B = 2'b10;

  // Change is always paid out in single Rs5 coins.
  localparam int CHANGE_UNIT = 5;

  function automatic logic [4:0] coin_value(input logic [1:0] c);
    logic [4:0] v;
    case (c)
      COIN_5:  v = 5'd5;
      COIN_10: v = 5'd10;
      COIN_20: v = 5'd20;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

endpackage : vend_pkg
`default_nettype wire

// File: rtl/vend_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : vend_timeout_ctr
// Description : Loadable down-counter for the inactivity timeout.
//               clear forces the count to zero, load reloads it, en counts
//               down (saturating at zero). expire is high whenever the counter
//               is enabled and already at zero.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous reset, active low
//               load     - load load_val into the counter
//               load_val - reload value
//               clear    - force the counter to zero (wins over load)
//               en       - count down one step
//               expire   - enabled while at zero (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module vend_timeout_ctr #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic             en,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Deliberately independent of load/clear so the controller can feed its
  // next-state back into load/clear without forming a combinational loop.
  assign expire = en && (count == '0);

endmodule : vend_timeout_ctr
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : vend_controller
// Description : Vending machine sequencer. Accumulates coin credit, checks a
//               product selection against its price, drives the dispenser
//               via vend_req/vend_done and pays change one Rs5 coin at a time
//               via chg_req/chg_ack. Cancel and inactivity timeout refund the
//               full credit. All outputs are registered.
// Ports       : clk         - clock, rising edge
//               rst         - asynchronous reset, active low
//               coin        - 00 none, 01 Rs5, 10 Rs10, 11 Rs20
//               sel         - 01 product A, 10 product B, else no request
//               cancel      - refund request pulse
//               vend_req    - dispense request, held until vend_done
//               vend_prod   - product being dispensed (0 = A, 1 = B)
//               vend_done   - dispenser completion pulse
//               chg_req     - eject one Rs5 coin, held until chg_ack
//               chg_ack     - ejector acknowledge pulse
//               coin_reject - one-cycle pulse when a coin is refused
//               credit      - current credit in rupees
//               busy        - high while vending or paying change
// Revision    : 1.0 - initial release
// ============================================================================
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_A     = 15,
  parameter int PRICE_B     = 20,
  parameter int MAX_CREDIT  = 40,
  parameter int CREDIT_W    = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic [1:0]          sel,
  input  logic                cancel,
  output logic                vend_req,
  output logic                vend_prod,
  input  logic                vend_done,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // One spare bit so credit + coin can be compared to the ceiling unwrapped.
  localparam int SUM_W = CREDIT_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SUM_W-1:0]    MAX_EXT = SUM_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PA      = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PB      = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W-1:0] UNIT    = CREDIT_W'(CHANGE_UNIT);
  localparam logic [TO_W-1:0]     TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

  generate
    if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_credit_width_check
      $error("vend_controller: MAX_CREDIT does not fit in CREDIT_W bits");
    end
  endgenerate

  vend_state_t         state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                reject_nxt;
  logic                prod_nxt;
  logic                vend_req_nxt;
  logic                chg_req_nxt;
  logic                busy_nxt;

  logic                coin_in;
  logic [SUM_W-1:0]    coin_v;
  logic [SUM_W-1:0]    sum;
  logic                sel_a;
  logic                sel_b;
  logic                activity;

  logic                to_load;
  logic                to_clear;
  logic                to_en;
  logic                to_expire;

  assign coin_in  = (coin != COIN_NONE);
  assign coin_v   = SUM_W'(coin_value(coin));
  assign sum      = {1'b0, credit} + coin_v;
  assign sel_a    = (sel == SEL_A);
  assign sel_b    = (sel == SEL_B);
  assign activity = coin_in || sel_a || sel_b || cancel;

  // The timer is reloaded on entry to COLLECT and on every customer action,
  // and held at zero everywhere else.
  assign to_en    = (state == ST_COLLECT) && !activity;
  assign to_clear = (state_nxt != ST_COLLECT);
  assign to_load  = (state_nxt == ST_COLLECT) && ((state != ST_COLLECT) || activity);

  vend_timeout_ctr #(
    .WIDTH (TO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TO_LOAD),
    .clear    (to_clear),
    .en       (to_en),
    .expire   (to_expire)
  );

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    reject_nxt = 1'b0;
    prod_nxt   = vend_prod;

    case (state)
      ST_IDLE: begin
        if (coin_in) begin
          if (sum <= MAX_EXT) begin
            credit_nxt = sum[CREDIT_W-1:0];
            state_nxt  = ST_COLLECT;
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        if (cancel) begin
          reject_nxt = coin_in;
          state_nxt  = ST_CHANGE;
        end else if (coin_in) begin
          if (sum <= MAX_EXT) begin
            credit_nxt = sum[CREDIT_W-1:0];
          end else begin
            reject_nxt = 1'b1;
          end
        end else if (sel_a && (credit >= PA)) begin
          credit_nxt = credit - PA;
          prod_nxt   = 1'b0;
          state_nxt  = ST_VEND;
        end else if (sel_b && (credit >= PB)) begin
          credit_nxt = credit - PB;
          prod_nxt   = 1'b1;
          state_nxt  = ST_VEND;
        end else if (to_expire) begin
          state_nxt = ST_CHANGE;
        end
      end

      ST_VEND: begin
        reject_nxt = coin_in;
        if (vend_done) begin
          state_nxt = (credit != '0) ? ST_CHANGE : ST_IDLE;
        end
      end

      ST_CHANGE: begin
        reject_nxt = coin_in;
        // Nothing left to pay out (e.g. cancel with zero credit): leave at once
        // instead of waiting on an ack that will never come.
        if (credit == '0) begin
          state_nxt = ST_IDLE;
        end else if (chg_ack) begin
          credit_nxt = credit - UNIT;
          if (credit_nxt == '0) begin
            state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Outputs are registered versions of what the next state implies.
    vend_req_nxt = (state_nxt == ST_VEND);
    chg_req_nxt  = (state_nxt == ST_CHANGE) && (credit_nxt != '0);
    busy_nxt     = (state_nxt == ST_VEND) || (state_nxt == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      credit      <= '0;
      vend_req    <= 1'b0;
      vend_prod   <= 1'b0;
      chg_req     <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      vend_req    <= vend_req_nxt;
      vend_prod   <= prod_nxt;
      chg_req     <= chg_req_nxt;
      coin_reject <= reject_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule : vend_controller
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_controller
// Description : Self-checking bench for vend_controller. A rupee-level model
//               tracks what the outputs must be every cycle; directed
//               scenarios add hand-computed checks on credit, handshakes,
//               ejection counts, timeout length and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

  localparam int PA   = 15;
  localparam int PB   = 20;
  localparam int MAXC = 40;
  localparam int CW   = 6;
  localparam int TO   = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    coin = 2'b00;
  logic [1:0]    sel = 2'b00;
  logic          cancel = 1'b0;
  logic          vend_done = 1'b0;
  logic          chg_ack = 1'b0;
  logic          vend_req;
  logic          vend_prod;
  logic          chg_req;
  logic          coin_reject;
  logic [CW-1:0] credit;
  logic          busy;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  vend_controller #(
    .PRICE_A     (PA),
    .PRICE_B     (PB),
    .MAX_CREDIT  (MAXC),
    .CREDIT_W    (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coin        (coin),
    .sel         (sel),
    .cancel      (cancel),
    .vend_req    (vend_req),
    .vend_prod   (vend_prod),
    .vend_done   (vend_done),
    .chg_req     (chg_req),
    .chg_ack     (chg_ack),
    .coin_reject (coin_reject),
    .credit      (credit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model (rupees and modes) ----------------
  // mode: 0 waiting for money, 1 taking coins, 2 dispensing, 3 refunding
  int m_credit = 0;
  int m_mode   = 0;
  int m_idle   = 0;
  bit m_prod   = 1'b0;
  bit m_rej    = 1'b0;

  always @(posedge clk or negedge rst) begin : mdl
    int cv;
    int price;
    if (!rst) begin
      m_credit = 0; m_mode = 0; m_idle = 0; m_prod = 1'b0; m_rej = 1'b0;
    end else begin
      case (coin)
        2'b01:   cv = 5;
        2'b10:   cv = 10;
        2'b11:   cv = 20;
        default: cv = 0;
      endcase
      m_rej = 1'b0;
      case (m_mode)
        0: if (cv > 0) begin
             m_credit = m_credit + cv; m_mode = 1; m_idle = 0;
           end
        1: begin
          if (cancel) begin
            m_rej = (cv > 0); m_mode = 3;
          end else if (cv > 0) begin
            if (m_credit + cv <= MAXC) m_credit = m_credit + cv;
            else m_rej = 1'b1;
            m_idle = 0;
          end else if (sel == 2'b01 || sel == 2'b10) begin
            price = (sel == 2'b01) ? PA : PB;
            if (m_credit >= price) begin
              m_credit = m_credit - price; m_prod = (sel == 2'b10); m_mode = 2;
            end
            m_idle = 0;
          end else if (m_idle == TO - 1) begin
            m_mode = 3;
          end else begin
            m_idle = m_idle + 1;
          end
        end
        2: begin
          m_rej = (cv > 0);
          if (vend_done) m_mode = (m_credit > 0) ? 3 : 0;
        end
        default: begin
          m_rej = (cv > 0);
          if (chg_ack && m_credit > 0) begin
            m_credit = m_credit - 5;
            if (m_credit == 0) m_mode = 0;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("mdl credit", int'(credit), m_credit);
      check("mdl vend_req", int'(vend_req), int'(m_mode == 2));
      check("mdl chg_req", int'(chg_req), int'(m_mode == 3 && m_credit > 0));
      check("mdl busy", int'(busy), int'(m_mode >= 2));
      check("mdl coin_reject", int'(coin_reject), int'(m_rej));
      if (m_mode == 2) check("mdl vend_prod", int'(vend_prod), int'(m_prod));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; holds the inputs across one rising edge.
  task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic cn,
                       input logic d, input logic a);
    coin = c; sel = s; cancel = cn; vend_done = d; chg_ack = a;
    @(negedge clk);
    coin = 2'b00; sel = 2'b00; cancel = 1'b0; vend_done = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic idle_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic serve_change(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (chg_req && guard < 20) begin
      drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      n++;
      guard++;
    end
  endtask

  initial begin : watchdog
    #500000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    check("rst credit", int'(credit), 0);
    check("rst vend_req", int'(vend_req), 0);
    check("rst chg_req", int'(chg_req), 0);
    check("rst busy", int'(busy), 0);
    check("rst coin_reject", int'(coin_reject), 0);
    check("rst vend_prod", int'(vend_prod), 0);
    rst = 1'b1;
    mon_en = 1'b1;
    idle_cycle();

    // 1: three Rs5 then product A, exact credit
    drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0); check("t1 credit5", int'(credit), 5);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0); check("t1 credit10", int'(credit), 10);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0); check("t1 credit15", int'(credit), 15);
    drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    check("t1 vend_req", int'(vend_req), 1);
    check("t1 vend_prod", int'(vend_prod), 0);
    check("t1 credit0", int'(credit), 0);
    idle_cycle(); check("t1 vend_req held", int'(vend_req), 1);
    drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    check("t1 vend_req drop", int'(vend_req), 0);
    check("t1 busy", int'(busy), 0);
    n = 0;
    repeat (3) begin
      if (chg_req) n++;
      idle_cycle();
    end
    check("t1 no chg_req", n, 0);

    // 2: Rs10+Rs10, product A, one Rs5 change; coin during VEND rejected
    drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0); check("t2 credit20", int'(credit), 20);
    drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0); check("t2 credit5", int'(credit), 5);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("t2 vend coin_reject", int'(coin_reject), 1);
    check("t2 vend credit", int'(credit), 5);
    drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    check("t2 chg_req", int'(chg_req), 1);
    serve_change(n);
    check("t2 ejections", n, 1);
    check("t2 end credit", int'(credit), 0);
    check("t2 end busy", int'(busy), 0);

    // 3: credit 30, over-limit Rs20 rejected, cancel refunds six coins
    drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0); check("t3 credit30", int'(credit), 30);
    drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    check("t3 coin_reject", int'(coin_reject), 1);
    check("t3 credit kept", int'(credit), 30);
    idle_cycle(); check("t3 reject pulse", int'(coin_reject), 0);
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0); check("t3 cancel chg_req", int'(chg_req), 1);
    serve_change(n);
    check("t3 ejections", n, 6);
    check("t3 end credit", int'(credit), 0);

    // 4: insufficient credit for B, coin beats sel, fill to ceiling, vend B
    drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
    check("t4 no vend", int'(vend_req), 0);
    check("t4 credit10", int'(credit), 10);
    drive(2'b01, 2'b10, 1'b0, 1'b0, 1'b0);
    check("t4 coin wins", int'(credit), 15);
    check("t4 sel ignored", int'(vend_req), 0);
    drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0); check("t4 credit35", int'(credit), 35);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("t4 credit40", int'(credit), 40);
    check("t4 at ceiling ok", int'(coin_reject), 0);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("t4 over ceiling", int'(coin_reject), 1);
    drive(2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
    check("t4 vend_req B", int'(vend_req), 1);
    check("t4 vend_prod B", int'(vend_prod), 1);
    check("t4 credit20", int'(credit), 20);
    drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    serve_change(n);
    check("t4 ejections", n, 4);

    // 5: inactivity timeout with Rs5 credit
    drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!chg_req && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    check("t5 timeout cycles", n, TO);
    serve_change(n);
    check("t5 ejections", n, 1);
    check("t5 end busy", int'(busy), 0);

    // 6: asynchronous reset in the middle of paying change
    drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    check("t6 mid change credit", int'(credit), 5);
    check("t6 mid change chg_req", int'(chg_req), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6 async chg_req", int'(chg_req), 0);
    check("t6 async busy", int'(busy), 0);
    check("t6 async credit", int'(credit), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0); check("t6 idle sel", int'(vend_req), 0);
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0); check("t6 idle cancel", int'(chg_req), 0);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("t6 idle coin", int'(credit), 5);
    check("t6 idle busy", int'(busy), 0);
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    serve_change(n);
    check("t6 ejections", n, 1);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_vend_controller
`default_nettype wire
